flag_sequencer: RTL and testbench

- Owns the architectural NZCV register for the execute stage.
- Sequences flag updates from two sources:
  - the single-cycle ALU;
  - the multi-cycle multiplier, whose flags arrive after a variable delay.
- Evaluates ARM condition codes against bypassed flags.
- Stalls execute when an instruction depends on flags the multiplier has not yet produced.
- Sits between the decode/execute pipeline registers and the hazard unit.

---
 rtl/flag_sequencer_if.sv | 29 ++
 rtl/flag_sequencer.sv | 124 ++++++++++++
 tb/tb_flag_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/flag_sequencer_if.sv
// Execute-stage flag sequencer bus: instruction controls and flag sources in,
// condition result, bypassed flags and hazard status out.
interface flag_sequencer_if;
  logic       ValidE;
  logic       FlushE;
  logic [3:0] CondE;
  logic [1:0] FlagsWriteE;
  logic       MultStartE;
  logic       MultDoneE;
  logic [3:0] MultFlagsE;
  logic [3:0] ALUFlagsE;
  logic       CondExE;
  logic [3:0] FlagsE;
  logic       FlagStallE;
  logic       MultBusyE;
  logic       MultTimeoutE;

  modport master (
    output ValidE, FlushE, CondE, FlagsWriteE, MultStartE, MultDoneE,
           MultFlagsE, ALUFlagsE,
    input  CondExE, FlagsE, FlagStallE, MultBusyE, MultTimeoutE
  );

  modport slave (
    input  ValidE, FlushE, CondE, FlagsWriteE, MultStartE, MultDoneE,
           MultFlagsE, ALUFlagsE,
    output CondExE, FlagsE, FlagStallE, MultBusyE, MultTimeoutE
  );
endinterface

// File: rtl/flag_sequencer.sv
// Owns the NZCV register, forwards late multiplier flags on their done cycle,
// evaluates ARM condition codes and stalls flag consumers behind a pending multiply.
module flag_sequencer #(
  parameter int MAX_MULT_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input logic              clk,
  input logic              reset,
  flag_sequencer_if.slave  bus
);

  typedef enum logic {IDLE, MULT_PEND} state_t;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_MULT_CYCLES);

  state_t           r_state, w_nextState;
  logic [3:0]       r_flags, w_nextFlags, w_flagsE;
  logic [1:0]       r_pendMask, w_nextMask;
  logic [CNT_W-1:0] r_waitCnt, w_nextCnt;
  logic             r_timeout, w_nextTimeout;
  logic             w_doneCycle, w_condPass, w_stall, w_accept;
  logic             w_n, w_z, w_c, w_v, w_ge;

  assign w_doneCycle = (r_state == MULT_PEND) && bus.MultDoneE;

  // Zero-cycle forwarding: only the fields the multiply owns are replaced.
  always_comb begin
    w_flagsE = r_flags;
    if (w_doneCycle) begin
      if (r_pendMask[1]) w_flagsE[3:2] = bus.MultFlagsE[3:2];
      if (r_pendMask[0]) w_flagsE[1:0] = bus.MultFlagsE[1:0];
    end
  end

  assign w_n  = w_flagsE[3];
  assign w_z  = w_flagsE[2];
  assign w_c  = w_flagsE[1];
  assign w_v  = w_flagsE[0];
  assign w_ge = (w_n == w_v);

  always_comb begin
    w_condPass = 1'b0;
    case (bus.CondE)
      4'b0000: w_condPass = w_z;
      4'b0001: w_condPass = ~w_z;
      4'b0010: w_condPass = w_c;
      4'b0011: w_condPass = ~w_c;
      4'b0100: w_condPass = w_n;
      4'b0101: w_condPass = ~w_n;
      4'b0110: w_condPass = w_v;
      4'b0111: w_condPass = ~w_v;
      4'b1000: w_condPass = w_c & ~w_z;
      4'b1001: w_condPass = ~(w_c & ~w_z);
      4'b1010: w_condPass = w_ge;
      4'b1011: w_condPass = ~w_ge;
      4'b1100: w_condPass = ~w_z & w_ge;
      4'b1101: w_condPass = ~(~w_z & w_ge);
      4'b1110: w_condPass = 1'b1;
      default: w_condPass = 1'b0;
    endcase
  end

  // Unconditional instructions that leave the flags alone need nothing from the multiply.
  assign w_stall = (r_state == MULT_PEND) && !bus.MultDoneE && bus.ValidE && !bus.FlushE &&
                   ((bus.CondE != 4'b1110) || (bus.FlagsWriteE != 2'b00));

  assign w_accept = bus.ValidE && !bus.FlushE && !w_stall && w_condPass;

  assign bus.CondExE      = w_accept;
  assign bus.FlagsE       = w_flagsE;
  assign bus.FlagStallE   = w_stall;
  assign bus.MultBusyE    = (r_state == MULT_PEND);
  assign bus.MultTimeoutE = r_timeout;

  always_comb begin
    w_nextState   = r_state;
    w_nextFlags   = r_flags;
    w_nextMask    = r_pendMask;
    w_nextCnt     = r_waitCnt;
    w_nextTimeout = r_timeout;

    if (r_state == MULT_PEND) begin
      if (bus.MultDoneE) begin
        w_nextFlags = w_flagsE;
        w_nextState = IDLE;
        w_nextMask  = 2'b00;
      end else begin
        if (r_waitCnt < CntMax) w_nextCnt = r_waitCnt + 1'b1;
        if (w_nextCnt == CntMax) w_nextTimeout = 1'b1;
      end
    end

    // The younger instruction is applied last so its ALU fields win per field.
    if (w_accept) begin
      if (bus.MultStartE) begin
        if (bus.FlagsWriteE != 2'b00) begin
          w_nextState = MULT_PEND;
          w_nextMask  = bus.FlagsWriteE;
          w_nextCnt   = '0;
        end
      end else begin
        if (bus.FlagsWriteE[1]) w_nextFlags[3:2] = bus.ALUFlagsE[3:2];
        if (bus.FlagsWriteE[0]) w_nextFlags[1:0] = bus.ALUFlagsE[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_flags    <= 4'b0000;
      r_pendMask <= 2'b00;
      r_waitCnt  <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_flags    <= w_nextFlags;
      r_pendMask <= w_nextMask;
      r_waitCnt  <= w_nextCnt;
      r_timeout  <= w_nextTimeout;
    end
  end

endmodule

// File: tb/tb_flag_sequencer.sv
// Scoreboarded bench for flag_sequencer: a behavioural model predicts every cycle's
// outputs, plus directed checks of the key forwarding, stall and watchdog scenarios.
module tb_flag_sequencer;

  typedef struct {
    logic       condEx;
    logic [3:0] flags;
    logic       stall;
    logic       busy;
    logic       timeout;
  } exp_t;

  logic clk;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;
  int   cycleNum   = 0;
  exp_t expQ[$];

  logic [3:0] mFlags   = 4'b0000;
  logic       mPend    = 1'b0;
  logic [1:0] mMask    = 2'b00;
  int         mCnt     = 0;
  logic       mTimeout = 1'b0;

  flag_sequencer_if bus ();

  flag_sequencer #(.MAX_MULT_CYCLES(16), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL timeout: simulation ran past its time limit");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic condTrue(input logic [3:0] cond, input logic [3:0] f);
    logic base;
    case (cond[3:1])
      3'b000:  base = f[2];
      3'b001:  base = f[1];
      3'b010:  base = f[3];
      3'b011:  base = f[0];
      3'b100:  base = f[1] && !f[2];
      3'b101:  base = (f[3] == f[0]);
      3'b110:  base = !f[2] && (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    if (cond == 4'b1111) return 1'b0;
    if (cond[0] && cond[3:1] != 3'b111) return !base;
    return base;
  endfunction

  // Drives one cycle, pushes the predicted outputs and advances the model past the next edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic f, input logic [3:0] cond,
                               input logic [1:0] fw, input logic ms, input logic md,
                               input logic [3:0] mf, input logic [3:0] af);
    exp_t       e;
    logic [3:0] byp;
    @(posedge clk);
    #1;
    reset           = rst;
    bus.ValidE      = v;
    bus.FlushE      = f;
    bus.CondE       = cond;
    bus.FlagsWriteE = fw;
    bus.MultStartE  = ms;
    bus.MultDoneE   = md;
    bus.MultFlagsE  = mf;
    bus.ALUFlagsE   = af;

    byp = mFlags;
    if (mPend && md) begin
      if (mMask[1]) byp[3:2] = mf[3:2];
      if (mMask[0]) byp[1:0] = mf[1:0];
    end
    e.flags   = byp;
    e.stall   = mPend && !md && v && !f && !(cond == 4'b1110 && fw == 2'b00);
    e.condEx  = v && !f && !e.stall && condTrue(cond, byp);
    e.busy    = mPend;
    e.timeout = mTimeout;
    expQ.push_back(e);

    if (rst) begin
      mFlags = 4'b0000; mPend = 1'b0; mMask = 2'b00; mCnt = 0; mTimeout = 1'b0;
    end else begin
      if (mPend) begin
        if (md) begin
          mFlags = byp; mPend = 1'b0; mMask = 2'b00;
        end else begin
          if (mCnt < 16) mCnt++;
          if (mCnt == 16) mTimeout = 1'b1;
        end
      end
      if (e.condEx) begin
        if (ms) begin
          if (fw != 2'b00) begin
            mPend = 1'b1; mMask = fw; mCnt = 0;
          end
        end else begin
          if (fw[1]) mFlags[3:2] = af[3:2];
          if (fw[0]) mFlags[1:0] = af[1:0];
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      cycleNum++;
      checkOutput($sformatf("cyc%0d CondExE", cycleNum),      8'(bus.CondExE),      8'(e.condEx));
      checkOutput($sformatf("cyc%0d FlagsE", cycleNum),       8'(bus.FlagsE),       8'(e.flags));
      checkOutput($sformatf("cyc%0d FlagStallE", cycleNum),   8'(bus.FlagStallE),   8'(e.stall));
      checkOutput($sformatf("cyc%0d MultBusyE", cycleNum),    8'(bus.MultBusyE),    8'(e.busy));
      checkOutput($sformatf("cyc%0d MultTimeoutE", cycleNum), 8'(bus.MultTimeoutE), 8'(e.timeout));
    end
  end

  initial begin
    reset = 1'b1;
    bus.ValidE = 1'b0; bus.FlushE = 1'b0; bus.CondE = 4'b0000; bus.FlagsWriteE = 2'b00;
    bus.MultStartE = 1'b0; bus.MultDoneE = 1'b0; bus.MultFlagsE = 4'b0000; bus.ALUFlagsE = 4'b0000;

    applyStimulus(1, 1, 0, 4'b0000, 2'b00, 0, 0, 4'h0, 4'h0);
    applyStimulus(1, 1, 0, 4'b0000, 2'b00, 0, 0, 4'h0, 4'h0);

    // Zero flags after reset.
    applyStimulus(0, 1, 0, 4'b0000, 2'b00, 0, 0, 4'h0, 4'h0);
    @(negedge clk); checkOutput("reset EQ", 8'(bus.CondExE), 8'd0);
    checkOutput("reset FlagsE", 8'(bus.FlagsE), 8'h0);
    checkOutput("reset busy", 8'(bus.MultBusyE), 8'd0);
    applyStimulus(0, 1, 0, 4'b0001, 2'b00, 0, 0, 4'h0, 4'h0);
    @(negedge clk); checkOutput("reset NE", 8'(bus.CondExE), 8'd1);
    applyStimulus(0, 1, 0, 4'b1111, 2'b00, 0, 0, 4'h0, 4'h0);
    @(negedge clk); checkOutput("cond 1111", 8'(bus.CondExE), 8'd0);

    // ALU write then consume.
    applyStimulus(0, 1, 0, 4'b1110, 2'b11, 0, 0, 4'h0, 4'b0100);
    applyStimulus(0, 1, 0, 4'b0000, 2'b00, 0, 0, 4'h0, 4'h0);
    @(negedge clk); checkOutput("alu FlagsE", 8'(bus.FlagsE), 8'h4);
    checkOutput("alu EQ", 8'(bus.CondExE), 8'd1);

    // Every condition against every flag pattern.
    for (int p = 0; p < 16; p++) begin
      applyStimulus(0, 1, 0, 4'b1110, 2'b11, 0, 0, 4'h0, 4'(p));
      for (int c = 0; c < 16; c++) applyStimulus(0, 1, 0, 4'(c), 2'b00, 0, 0, 4'h0, 4'h0);
    end

    // Multiply pending on N,Z with C,V preserved.
    applyStimulus(0, 1, 0, 4'b1110, 2'b11, 0, 0, 4'h0, 4'b0011);
    applyStimulus(0, 1, 0, 4'b1110, 2'b10, 1, 0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 4'b0000, 2'b00, 0, 0, 4'h0, 4'h0);
    @(negedge clk); checkOutput("pend stall", 8'(bus.FlagStallE), 8'd1);
    checkOutput("pend busy", 8'(bus.MultBusyE), 8'd1);
    checkOutput("pend CondExE", 8'(bus.CondExE), 8'd0);
    applyStimulus(0, 1, 0, 4'b0000, 2'b00, 0, 1, 4'b0100, 4'h0);
    @(negedge clk); checkOutput("done stall", 8'(bus.FlagStallE), 8'd0);
    checkOutput("done CondExE", 8'(bus.CondExE), 8'd1);
    checkOutput("done bypass", 8'(bus.FlagsE), 8'h7);
    applyStimulus(0, 1, 0, 4'b1110, 2'b00, 0, 0, 4'h0, 4'h0);
    @(negedge clk); checkOutput("done commit", 8'(bus.FlagsE), 8'h7);
    checkOutput("done idle", 8'(bus.MultBusyE), 8'd0);

    // AL bypass, then done colliding with a younger C,V write.
    applyStimulus(0, 1, 0, 4'b1110, 2'b11, 1, 0, 4'h0, 4'h0);
    applyStimulus(0, 1, 0, 4'b1110, 2'b00, 0, 0, 4'h0, 4'h0);
    @(negedge clk); checkOutput("AL no stall", 8'(bus.FlagStallE), 8'd0);
    checkOutput("AL executes", 8'(bus.CondExE), 8'd1);
    applyStimulus(0, 1, 0, 4'b1110, 2'b01, 0, 1, 4'b1000, 4'b0011);
    applyStimulus(0, 1, 0, 4'b1110, 2'b00, 0, 0, 4'h0, 4'h0);
    @(negedge clk); checkOutput("collision", 8'(bus.FlagsE), 8'hB);

    // Flush of a start, flush under a pending multiply, done with a back-to-back start.
    applyStimulus(0, 1, 1, 4'b1110, 2'b11, 1, 0, 4'h0, 4'h0);
    applyStimulus(0, 0, 0, 4'b1110, 2'b00, 0, 0, 4'h0, 4'h0);
    @(negedge clk); checkOutput("flushed start", 8'(bus.MultBusyE), 8'd0);
    applyStimulus(0, 1, 0, 4'b1110, 2'b11, 1, 0, 4'h0, 4'h0);
    applyStimulus(0, 1, 1, 4'b0000, 2'b11, 0, 0, 4'h0, 4'h0);
    @(negedge clk); checkOutput("flush no stall", 8'(bus.FlagStallE), 8'd0);
    applyStimulus(0, 1, 0, 4'b1110, 2'b01, 1, 1, 4'b0101, 4'h0);
    applyStimulus(0, 0, 0, 4'b0000, 2'b00, 0, 0, 4'h0, 4'h0);
    @(negedge clk); checkOutput("restart busy", 8'(bus.MultBusyE), 8'd1);
    checkOutput("restart flags", 8'(bus.FlagsE), 8'h5);
    applyStimulus(0, 0, 0, 4'b0000, 2'b00, 0, 1, 4'b1110, 4'h0);
    applyStimulus(0, 0, 0, 4'b0000, 2'b00, 0, 1, 4'b0000, 4'h0);
    @(negedge clk); checkOutput("idle done ignored", 8'(bus.FlagsE), 8'h6);

    // Watchdog, sticky error, reset mid-pend.
    applyStimulus(0, 1, 0, 4'b1110, 2'b11, 1, 0, 4'h0, 4'h0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 4'b0000, 2'b00, 0, 0, 4'h0, 4'h0);
    @(negedge clk); checkOutput("wdog early", 8'(bus.MultTimeoutE), 8'd0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 4'b0000, 2'b00, 0, 0, 4'h0, 4'h0);
    @(negedge clk); checkOutput("wdog fired", 8'(bus.MultTimeoutE), 8'd1);
    checkOutput("wdog still pend", 8'(bus.MultBusyE), 8'd1);
    applyStimulus(0, 0, 0, 4'b0000, 2'b00, 0, 1, 4'h9, 4'h0);
    applyStimulus(0, 1, 0, 4'b1110, 2'b11, 1, 0, 4'h0, 4'h0);
    @(negedge clk); checkOutput("wdog sticky", 8'(bus.MultTimeoutE), 8'd1);
    applyStimulus(1, 0, 0, 4'b0000, 2'b00, 0, 1, 4'hF, 4'h0);
    applyStimulus(0, 0, 0, 4'b0000, 2'b00, 0, 1, 4'hF, 4'h0);
    @(negedge clk); checkOutput("rst busy", 8'(bus.MultBusyE), 8'd0);
    checkOutput("rst timeout", 8'(bus.MultTimeoutE), 8'd0);
    checkOutput("rst flags", 8'(bus.FlagsE), 8'h0);
    applyStimulus(0, 1, 0, 4'b0000, 2'b00, 0, 0, 4'h0, 4'h0);
    @(negedge clk); checkOutput("rst done ignored", 8'(bus.FlagsE), 8'h0);

    // Constrained-random traffic checked purely by the scoreboard.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(63) == 0), ($urandom_range(3) != 0), ($urandom_range(7) == 0),
                    4'($urandom_range(15)), 2'($urandom_range(3)), ($urandom_range(3) == 0),
                    ($urandom_range(2) == 0), 4'($urandom_range(15)), 4'($urandom_range(15)));
    end

    @(negedge clk);
    @(negedge clk);
    checkOutput("queue drained", 8'(expQ.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
